// File: rtl/row_by_vector_issuer_pkg.sv
// Shared types and constants for the row-by-vector issuer and its result collector.
// No logic here; holds the FSM encoding, chunk geometry and the multiples helper.
// Not applicable (no datapath).
package row_by_vector_issuer_pkg;

   localparam int RBV_ELEM_W      = 64;
   localparam int ELEMS_PER_CHUNK = 3;
   localparam int RBV_CHUNK_W     = ELEMS_PER_CHUNK * RBV_ELEM_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_GAP,
      S_DRAIN,
      S_DONE
   } state_t;

   // A zero multiples count is meaningless for the unit; treat it as one chunk per row.
   function automatic int unsigned eff_mult(input int unsigned m);
      return (m == 0) ? 1 : m;
   endfunction

endpackage

// File: rtl/row_by_vector_result_collector.sv
// Captures row results from the row-by-vector unit and writes them to the output vector memory.
// One cycle from decoder_read_now to y_wr_en/y_addr/y_data.
// No backpressure: every pulse seen while active is written; pulses while inactive are dropped.
module row_by_vector_result_collector
   import row_by_vector_issuer_pkg::*;
#(
   parameter int ROW_W  = 8,
   parameter int ELEM_W = RBV_ELEM_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              active,
`ifdef ROW_BY_VECTOR_ISSUER_CHECK_EN
   input  logic [ROW_W-1:0]  rows_issued,
`endif
   input  logic              decoder_read_now,
   input  logic [ELEM_W-1:0] result,
   output logic              y_wr_en,
   output logic [ROW_W-1:0]  y_addr,
   output logic [ELEM_W-1:0] y_data,
   output logic [ROW_W-1:0]  collected
`ifdef ROW_BY_VECTOR_ISSUER_CHECK_EN
   ,
   output logic              err
`endif
);

   // Result counter and registered write port; results land in row order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_wr_en   <= 1'b0;
         y_addr    <= '0;
         y_data    <= '0;
         collected <= '0;
      end else begin
         y_wr_en <= 1'b0;
         if (clear) begin
            collected <= '0;
         end else if (active && decoder_read_now) begin
            y_wr_en   <= 1'b1;
            y_addr    <= collected;
            y_data    <= result;
            collected <= collected + ROW_W'(1);
         end
      end
   end

`ifdef ROW_BY_VECTOR_ISSUER_CHECK_EN
   // Sticky flag for results nobody asked for: more results than rows issued, or any while idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err <= 1'b0;
      end else if (clear) begin
         err <= 1'b0;
      end else if (decoder_read_now && (!active || (collected >= rows_issued))) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: rtl/row_by_vector_issuer.sv
// Sequences a matrix-by-vector product: reads row/vector chunks, feeds the row-by-vector unit, stores results.
// mem_rd_en one cycle after accepted start; start_row_by_vector one cycle after mem_rd_en; y write one cycle after decoder_read_now.
// No backpressure; a one-cycle bubble after each row. Optional err output under ROW_BY_VECTOR_ISSUER_CHECK_EN.
module row_by_vector_issuer
   import row_by_vector_issuer_pkg::*;
#(
   parameter int CHUNK_W = RBV_CHUNK_W,
   parameter int ELEM_W  = RBV_ELEM_W,
   parameter int ADDR_W  = 12,
   parameter int ROW_W   = 8,
   parameter int MULT_W  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ROW_W-1:0]   num_rows,
   input  logic [MULT_W-1:0]  num_multiples,
   output logic               busy,
   output logic               done,
   output logic               mem_rd_en,
   output logic [ADDR_W-1:0]  row_addr,
   output logic [MULT_W-1:0]  vec_addr,
   input  logic [CHUNK_W-1:0] row_data,
   input  logic [CHUNK_W-1:0] vec_data,
   output logic [CHUNK_W-1:0] a,
   output logic [CHUNK_W-1:0] p,
   output logic               start_row_by_vector,
   output logic [MULT_W-1:0]  number_of_multiples,
   input  logic               decoder_read_now,
   input  logic [ELEM_W-1:0]  result,
   output logic               y_wr_en,
   output logic [ROW_W-1:0]   y_addr,
   output logic [ELEM_W-1:0]  y_data
`ifdef ROW_BY_VECTOR_ISSUER_CHECK_EN
   ,
   output logic               err
`endif
);

   state_t              state, state_n;
   logic [ROW_W-1:0]    num_rows_q;
   logic [MULT_W-1:0]   mult_q;
   logic [MULT_W-1:0]   chunk_k;
   logic [ADDR_W-1:0]   addr_cnt;
   logic [ROW_W-1:0]    rows_issued;
   logic [ROW_W-1:0]    collected;
   logic                accept;
   logic                issue;
   logic                last_chunk;

   assign accept              = (state == S_IDLE) && start;
   assign last_chunk          = (chunk_k == (mult_q - MULT_W'(1)));
   assign busy                = (state == S_ISSUE) || (state == S_GAP) || (state == S_DRAIN);
   assign done                = (state == S_DONE);
   assign number_of_multiples = mult_q;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // Next-state and issue decision; the issued chunk is registered onto the memory port next edge.
   always_comb begin
      state_n = state;
      issue   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_n = (num_rows == '0) ? S_DONE : S_ISSUE;
         end
         S_ISSUE: begin
            issue = 1'b1;
            if (last_chunk) state_n = S_GAP;
         end
         S_GAP: begin
            state_n = (rows_issued == num_rows_q) ? S_DRAIN : S_ISSUE;
         end
         S_DRAIN: begin
            if (collected == num_rows_q) state_n = S_DONE;
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Job parameters, chunk/row counters and the registered memory read port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         num_rows_q  <= '0;
         mult_q      <= '0;
         chunk_k     <= '0;
         addr_cnt    <= '0;
         rows_issued <= '0;
         mem_rd_en   <= 1'b0;
         row_addr    <= '0;
         vec_addr    <= '0;
      end else begin
         mem_rd_en <= issue;
         if (accept) begin
            num_rows_q  <= num_rows;
            mult_q      <= MULT_W'(eff_mult(32'(num_multiples)));
            chunk_k     <= '0;
            addr_cnt    <= '0;
            rows_issued <= '0;
         end else if (issue) begin
            row_addr <= addr_cnt;
            vec_addr <= chunk_k;
            addr_cnt <= addr_cnt + ADDR_W'(1);
            if (last_chunk) begin
               chunk_k     <= '0;
               rows_issued <= rows_issued + ROW_W'(1);
            end else begin
               chunk_k <= chunk_k + MULT_W'(1);
            end
         end
      end
   end

   // Read data arrives the cycle after mem_rd_en; register it toward the unit with its strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a                   <= '0;
         p                   <= '0;
         start_row_by_vector <= 1'b0;
      end else begin
         start_row_by_vector <= mem_rd_en;
         if (mem_rd_en) begin
            a <= row_data;
            p <= vec_data;
         end
      end
   end

   row_by_vector_result_collector #(
      .ROW_W  (ROW_W),
      .ELEM_W (ELEM_W)
   ) u_collector (
      .clk              (clk),
      .reset            (reset),
      .clear            (accept),
      .active           (state != S_IDLE),
`ifdef ROW_BY_VECTOR_ISSUER_CHECK_EN
      .rows_issued      (rows_issued),
`endif
      .decoder_read_now (decoder_read_now),
      .result           (result),
      .y_wr_en          (y_wr_en),
      .y_addr           (y_addr),
      .y_data           (y_data),
      .collected        (collected)
`ifdef ROW_BY_VECTOR_ISSUER_CHECK_EN
      ,
      .err              (err)
`endif
   );

endmodule

// File: doc/row_by_vector_issuer.md
Name: row_by_vector_issuer

Overview:
- Sequences a full matrix-by-vector product through the complex row-by-vector unit, acting as its feeding and collecting end.
- Reads 3-element complex chunks of matrix rows and the vector from synchronous memories.
- Drives the unit's a/p/start_row_by_vector/number_of_multiples inputs.
- Captures each row result on decoder_read_now and writes it into the output vector memory.

Parameters:
- CHUNK_W, 192, width of one chunk (3 complex elements of 64 bits)
- ELEM_W, 64, width of one complex result (32-bit real in the upper half, 32-bit imag in the lower half)
- ADDR_W, 12, row-memory address width
- ROW_W, 8, row count / output index width
- MULT_W, 4, chunks-per-row (multiples) width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle request; sampled only in IDLE
- num_rows  in  ROW_W  rows to process; latched on accepted start
- num_multiples  in  MULT_W  chunks per row; latched on start; 0 is treated as 1
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the last result has been written
- mem_rd_en  out  1  read strobe to the row and vector memories
- row_addr  out  ADDR_W  row-memory chunk address
- vec_addr  out  MULT_W  vector-memory chunk address
- row_data  in  CHUNK_W  row chunk, valid 1 cycle after mem_rd_en
- vec_data  in  CHUNK_W  vector chunk, valid 1 cycle after mem_rd_en
- a  out  CHUNK_W  row chunk to the row-by-vector unit (registered)
- p  out  CHUNK_W  vector chunk to the row-by-vector unit (registered)
- start_row_by_vector  out  1  chunk-valid strobe to the unit
- number_of_multiples  out  MULT_W  latched multiples count, held constant while busy
- decoder_read_now  in  1  result-valid pulse from the unit
- result  in  ELEM_W  row result from the unit
- y_wr_en  out  1  output-memory write strobe
- y_addr  out  ROW_W  output-memory index
- y_data  out  ELEM_W  row result to store

Behaviour:
- Reset values: every output is 0; FSM in IDLE; all counters 0.
- FSM states: IDLE, ISSUE, GAP, DRAIN, DONE.
  - IDLE: start=1 latches num_rows and num_multiples (0 becomes 1) and sets busy. Goes to DONE if num_rows==0, otherwise to ISSUE.
  - ISSUE: mem_rd_en=1 every cycle. Each cycle row_addr increments by 1 from 0 and vec_addr = chunk index k (0..M-1). After the chunk with k==M-1, go to GAP.
  - GAP: exactly one cycle with mem_rd_en=0. This is the unit's per-row counter turnaround. Then return to ISSUE if rows remain, otherwise go to DRAIN.
  - DRAIN: wait until results collected == num_rows, then go to DONE.
  - DONE: done=1 for one cycle, busy drops, return to IDLE.
- Read/issue timing:
  - Memory read latency is fixed at 1 cycle.
  - The cycle after each mem_rd_en: a<=row_data, p<=vec_data, start_row_by_vector<=1.
  - start_row_by_vector therefore lags mem_rd_en by exactly 1 cycle, and GAP bubbles propagate.
  - a/p hold their last value when the strobe is low.
  - Accepted start at edge 0: mem_rd_en=1 after edge 1, start_row_by_vector=1 after edge 2.
- Collection:
  - Each decoder_read_now=1 cycle drives y_wr_en=1, y_data=result, y_addr=result counter on the next edge. The result counter then increments.
  - Collection runs concurrently with ISSUE/GAP; results are in row order.
  - No backpressure exists; every pulse is written.
- Row address arithmetic: row_addr wraps modulo 2^ADDR_W. num_rows*num_multiples beyond the memory size is a caller error.
- Start while busy: ignored, no effect.
- decoder_read_now in IDLE: ignored (not written).
- Reset mid-operation: immediate return to IDLE with all outputs 0. Results still in flight in the unit are discarded.

Optional Feature:
- Macro: ROW_BY_VECTOR_ISSUER_CHECK_EN.
- With the macro defined, an extra output err (1 bit, reset 0) is added. err sets sticky when:
  - decoder_read_now arrives with results collected ≥ rows issued, or
  - decoder_read_now arrives in IDLE.
  err clears only on reset or an accepted start.
- Without the macro: no err port, no check logic.

Decomposition:
- Shared package:
  - FSM state enum
  - CHUNK_W/ELEM_W constants
  - ELEMS_PER_CHUNK=3
  - function for the effective multiples count (0 to 1)
- One natural sub-module: row_by_vector_result_collector, holding the result counter, y_* registers and the optional err check. The FSM and address generation stay in the top.

Test Plan:
- num_rows=1, num_multiples=1, start at edge 0:
  - mem_rd_en high only after edge 1, row_addr=0, vec_addr=0.
  - start_row_by_vector pulse after edge 2, a=row_data.
  - bench pulses decoder_read_now with result=64'h3F800000_40000000: y_wr_en, y_addr=0, that y_data; done pulse follows.
- num_rows=3, num_multiples=2:
  - mem_rd_en pattern 1,1,0,1,1,0,1,1; row_addr 0,1,-,2,3,-,4,5; vec_addr 0,1,-,0,1,-,0,1.
  - 3 result pulses land at y_addr 0,1,2; done only after the third.
- num_rows=0 → done 1 cycle after start, mem_rd_en never asserted. num_multiples=0 with num_rows=2 behaves as multiples=1.
- Reset asserted mid-ISSUE (row 1) → all outputs 0 without a clock edge. A new start then restarts from row_addr=0.
- start pulsed while busy → ignored; latched num_rows unchanged; number_of_multiples steady throughout.
- With ROW_BY_VECTOR_ISSUER_CHECK_EN:
  - decoder_read_now in IDLE → err=1 and stays 1.
  - next accepted start → err=0.
  - 2 rows issued, 3 pulses → err=1.
